// File: rtl/c_hazard_controller.sv
// Pipeline sequencer: stall/flush/bubble control, EX forwarding selects,
// post-reset warm-up and multi-cycle execute start/done sequencing.
module c_hazard_controller #(
  parameter int WARMUP_CYCLES = 2,
  parameter int MC_TIMEOUT    = 64,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             MemReadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MultiCycleE,
  input  logic             MCDoneE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MCStartE,
  output logic             MCTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int TW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    RUN     = 2'd1,
    MC_BUSY = 2'd2
  } state_t;

  state_t          state;
  logic [WW-1:0]   warm_cnt;
  logic [TW-1:0]   to_cnt;
  logic            mc_timeout;
  logic            lw_stall;
  logic            to_last;

  assign lw_stall = MemReadE && (RdE != 5'd0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));
  assign to_last  = (to_cnt == TW'(MC_TIMEOUT - 1));

  // M stage has priority: it holds the younger result.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
      ForwardAE = 2'b01;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
      ForwardBE = 2'b01;
  end

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    MCStartE = 1'b0;
    unique case (state)
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (MultiCycleE) begin
          MCStartE = 1'b1;
          StallF   = 1'b1;
          StallD   = 1'b1;
          StallE   = 1'b1;
          FlushM   = 1'b1;
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MC_BUSY: begin
        // done or timeout releases the stall in the same cycle
        if (!MCDoneE && !to_last) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end
      end
      default: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WARMUP;
      warm_cnt   <= WW'(WARMUP_CYCLES - 1);
      to_cnt     <= '0;
      mc_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (MCStartE) begin
            to_cnt <= '0;
            state  <= MC_BUSY;
          end
        end
        MC_BUSY: begin
          if (MCDoneE) begin
            state <= RUN;
          end else if (to_last) begin
            mc_timeout <= 1'b1;
            state      <= RUN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          if (warm_cnt == '0)
            state <= RUN;
          else
            warm_cnt <= warm_cnt - 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      StallCount <= '0;
    else if (StallD && !(&StallCount))
      StallCount <= StallCount + 1'b1;
  end

  assign MCTimeout = mc_timeout;

endmodule
